// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and an optional iterative multiplier.
// Define ALU_SEQ_MUL_EN to build the shift-add MUL path (opcode 1000); otherwise 1000 is illegal.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       aluSel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SRA = 4'b1101;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int CW = $clog2(WIDTH + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
`ifdef ALU_SEQ_MUL_EN
    , S_EXEC = 2'd1
`endif
  } state_t;

  state_t state;
  state_t state_next;
  state_t accept_state;
  logic   accept;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] op_result;
  logic             op_carry;
  logic             op_overflow;
  logic             op_illegal;

`ifdef ALU_SEQ_MUL_EN
  logic             op_mul;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
`endif

  // A new operation may enter when idle, or when the held result leaves this same cycle.
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_ready && in_valid;

  always_comb begin
    add_sum     = {1'b0, in1} + {1'b0, in2};
    sub_sum     = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};
    shamt       = in2[SHW-1:0];
    op_result   = '0;
    op_carry    = 1'b0;
    op_overflow = 1'b0;
    op_illegal  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    op_mul      = 1'b0;
`endif
    case (aluSel)
      OP_AND: op_result = in1 & in2;
      OP_OR:  op_result = in1 | in2;
      OP_XOR: op_result = in1 ^ in2;
      OP_NOR: op_result = ~(in1 | in2);
      OP_ADD: begin
        op_result   = add_sum[WIDTH-1:0];
        op_carry    = add_sum[WIDTH];
        op_overflow = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        op_result   = sub_sum[WIDTH-1:0];
        op_carry    = sub_sum[WIDTH];
        op_overflow = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLL: op_result = in1 << shamt;
      OP_SRL: op_result = in1 >> shamt;
      OP_SRA: op_result = $signed(in1) >>> shamt;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: op_mul = 1'b1;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

  always_comb begin
`ifdef ALU_SEQ_MUL_EN
    accept_state = op_mul ? S_EXEC : S_DONE;
`else
    accept_state = S_DONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid) state_next = accept_state;
`ifdef ALU_SEQ_MUL_EN
      S_EXEC: if (count == CW'(WIDTH)) state_next = S_DONE;
`endif
      S_DONE: if (out_ready) state_next = in_valid ? accept_state : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The multiplier runs WIDTH add/shift steps, then spends one more cycle publishing the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
      if (op_mul) begin
        mcand     <= in1;
        mplier    <= in2;
        acc       <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else
`endif
      begin
        result    <= op_result;
        zero      <= (op_result == '0);
        carry     <= op_carry;
        overflow  <= op_overflow;
        negative  <= op_result[WIDTH-1];
        illegal   <= op_illegal;
        out_valid <= 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
    end else if (state == S_EXEC) begin
      if (count == CW'(WIDTH)) begin
        result    <= acc;
        zero      <= (acc == '0);
        carry     <= 1'b0;
        overflow  <= 1'b0;
        negative  <= acc[WIDTH-1];
        illegal   <= 1'b0;
        out_valid <= 1'b1;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
`endif
    end else if ((state == S_DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); covers both ALU_SEQ_MUL_EN builds.
module tb_alu_seq;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SRA = 4'b1101;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  aluSel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, carry, overflow, negative, illegal;

  int checks = 0;
  int fails  = 0;

  // {out_valid, zero, carry, overflow, negative, illegal}
  wire [5:0] flags = {out_valid, zero, carry, overflow, negative, illegal};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .aluSel(aluSel), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .negative(negative), .illegal(illegal)
  );

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    @(negedge clk);
    in1 = a; in2 = b; aluSel = op; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; aluSel = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h0) begin fails++; $display("[TB] FAIL reset_result: got %h expected %h", result, 32'h0); end
    checks++;
    if (flags !== 6'b010000) begin fails++; $display("[TB] FAIL reset_flags: got %b expected %b", flags, 6'b010000); end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    send(32'hFFFFFFFF, 32'h00000001, OP_ADD);
    checks++;
    if (result !== 32'h0) begin fails++; $display("[TB] FAIL add_wrap_result: got %h expected %h", result, 32'h0); end
    checks++;
    if (flags !== 6'b111000) begin fails++; $display("[TB] FAIL add_wrap_flags: got %b expected %b", flags, 6'b111000); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL add_drain: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_sub_slt;
    send(32'h80000000, 32'h00000001, OP_SUB);
    checks++;
    if (result !== 32'h7FFFFFFF) begin fails++; $display("[TB] FAIL sub_result: got %h expected %h", result, 32'h7FFFFFFF); end
    checks++;
    if (flags !== 6'b101100) begin fails++; $display("[TB] FAIL sub_flags: got %b expected %b", flags, 6'b101100); end
    send(32'hFFFFFFFF, 32'h00000001, OP_SLT);
    checks++;
    if (result !== 32'h1) begin fails++; $display("[TB] FAIL slt_result: got %h expected %h", result, 32'h1); end
    checks++;
    if (flags !== 6'b100000) begin fails++; $display("[TB] FAIL slt_flags: got %b expected %b", flags, 6'b100000); end
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_mul;
    logic [31:0] a_tab [2];
    logic [31:0] b_tab [2];
    logic [31:0] p_tab [2];
    int cycles;
    bit ready_seen;
    a_tab = '{32'd7, 32'hFFFFFFFF};
    b_tab = '{32'd6, 32'hFFFFFFFF};
    p_tab = '{32'd42, 32'h00000001};
    for (int i = 0; i < 2; i++) begin
      send(a_tab[i], b_tab[i], OP_MUL);
      cycles = 0;
      ready_seen = 1'b0;
      while (out_valid !== 1'b1 && cycles < 100) begin
        if (in_ready !== 1'b0) ready_seen = 1'b1;
        @(posedge clk);
        #1;
        cycles++;
      end
      checks++;
      if (cycles != 33) begin fails++; $display("[TB] FAIL mul_latency[%0d]: got %0d clocks expected 33", i, cycles); end
      checks++;
      if (ready_seen) begin fails++; $display("[TB] FAIL mul_in_ready_exec[%0d]: got in_ready 1 expected 0", i); end
      checks++;
      if (result !== p_tab[i]) begin fails++; $display("[TB] FAIL mul_result[%0d]: got %h expected %h", i, result, p_tab[i]); end
      checks++;
      if (flags !== 6'b100000) begin fails++; $display("[TB] FAIL mul_flags[%0d]: got %b expected %b", i, flags, 6'b100000); end
    end
  endtask
`endif

  task automatic test_back_to_back;
    logic [31:0] expv;
    logic [31:0] last;
    out_ready = 1'b1;
    last = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in1 = 32'(i) * 32'h100; in2 = 32'(i + 1); aluSel = OP_ADD; in_valid = 1'b1;
      expv = 32'(i) * 32'h101 + 32'd1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, result} !== {1'b1, expv}) begin
        fails++; $display("[TB] FAIL b2b_result[%0d]: got %b/%h expected 1/%h", i, out_valid, result, expv);
      end
      last = expv;
    end
    // Stall the consumer while a new operation waits upstream.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in1 = 32'd100; in2 = 32'd23; aluSel = OP_ADD; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if ({flags, result} !== {6'b100000, last}) begin
        fails++; $display("[TB] FAIL stall_hold[%0d]: got %b/%h expected %b/%h", i, flags, result, 6'b100000, last);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result} !== {1'b1, 32'd123}) begin
      fails++; $display("[TB] FAIL stall_release: got %b/%h expected 1/%h", out_valid, result, 32'd123);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [5:0]  fl;
  } vec_t;

  task automatic test_logic_shifts;
    vec_t vecs [9];
    vecs = '{
      '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 6'b100010},
      '{OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 6'b100010},
      '{OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 6'b100000},
      '{OP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 6'b100000},
      '{OP_SRA, 32'h80000000, 32'd31,       32'hFFFFFFFF, 6'b100010},
      '{OP_SLL, 32'h00000001, 32'h00000024, 32'h00000010, 6'b100000},
      '{OP_SRL, 32'hA5A5A5A5, 32'h00000020, 32'hA5A5A5A5, 6'b100010},
      '{OP_SRL, 32'h80000000, 32'd4,        32'h08000000, 6'b100000},
      '{OP_SRA, 32'h40000000, 32'd4,        32'h04000000, 6'b100000}
    };
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op);
      checks++;
      if ({flags, result} !== {vecs[i].fl, vecs[i].res}) begin
        fails++; $display("[TB] FAIL vec[%0d] op %b: got %b/%h expected %b/%h", i, vecs[i].op, flags, result, vecs[i].fl, vecs[i].res);
      end
    end
  endtask

  task automatic test_reset_mid_op;
`ifdef ALU_SEQ_MUL_EN
    send(32'd123, 32'd456, OP_MUL);
    repeat (9) @(posedge clk);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({flags, result} !== {6'b010000, 32'h0}) begin
      fails++; $display("[TB] FAIL mid_reset_outputs: got %b/%h expected %b/%h", flags, result, 6'b010000, 32'h0);
    end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_no_output: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_illegal;
    send(32'd1, 32'd1, OP_ADD);
    checks++;
    if ({flags, result} !== {6'b100000, 32'd2}) begin
      fails++; $display("[TB] FAIL pre_illegal_add: got %b/%h expected %b/%h", flags, result, 6'b100000, 32'd2);
    end
    send(32'd5, 32'd5, 4'b1111);
    checks++;
    if ({flags, result} !== {6'b110001, 32'h0}) begin
      fails++; $display("[TB] FAIL illegal_1111: got %b/%h expected %b/%h", flags, result, 6'b110001, 32'h0);
    end
    send(32'd2, 32'd3, OP_ADD);
    checks++;
    if ({flags, result} !== {6'b100000, 32'd5}) begin
      fails++; $display("[TB] FAIL illegal_clear: got %b/%h expected %b/%h", flags, result, 6'b100000, 32'd5);
    end
`ifndef ALU_SEQ_MUL_EN
    send(32'd7, 32'd6, OP_MUL);
    checks++;
    if ({flags, result} !== {6'b110001, 32'h0}) begin
      fails++; $display("[TB] FAIL illegal_mul_disabled: got %b/%h expected %b/%h", flags, result, 6'b110001, 32'h0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
`ifdef ALU_SEQ_MUL_EN
    test_mul();
`endif
    test_back_to_back();
    test_logic_shifts();
    test_reset_mid_op();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle combinational ALU used in the datapath labs. Keeps the existing aluSel encodings (AND/OR/ADD/SUB) and adds XOR, NOR, SLT, shifts, status flags and an iterative shift-add multiplier. Operand and result transfers use valid/ready handshakes so the block can sit between pipeline stages or be driven by a multi-cycle control FSM.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 4..64.
SHW, $clog2(WIDTH), local; number of in2 LSBs used as the shift amount.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operands and opcode valid.
in_ready  out  1  block can accept an operation this cycle.
in1  in  WIDTH  operand A.
in2  in  WIDTH  operand B.
aluSel  in  4  opcode; captured on accept.
out_valid  out  1  result and flags valid.
out_ready  in  1  consumer accepts the result.
result  out  WIDTH  registered result.
zero  out  1  result == 0.
carry  out  1  ADD: carry-out. SUB: 1 when in1 >= in2 unsigned (no borrow). Otherwise 0.
overflow  out  1  signed overflow, ADD/SUB only; otherwise 0.
negative  out  1  result[WIDTH-1].
illegal  out  1  captured opcode was unsupported.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0011 XOR; 1100 NOR.
  - 0111 SLT: signed compare, result 1 or 0.
  - 0100 SLL, 0101 SRL, 1101 SRA: shift in1 by in2[SHW-1:0].
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - Any other opcode: result 0, illegal=1, all other flags computed from result 0 (zero=1).
- Arithmetic:
  - ADD/SUB computed at WIDTH+1 bits; carry is bit WIDTH.
  - SUB is in1 + ~in2 + 1.
  - Overflow = operand sign bits agree (B inverted for SUB) and the result sign differs.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid, capture in1, in2 and aluSel. Single-cycle ops go to DONE. MUL goes to EXEC with count=0.
  - EXEC: in_ready=0, out_valid=0. Each cycle:
    - If multiplier LSB is 1, add multiplicand to accumulator.
    - Shift multiplicand left and multiplier right; count++.
    - After WIDTH iterations, load result and go to DONE.
  - DONE: out_valid=1; result and flags held stable until out_ready=1.
    - If out_ready=1 and in_valid=1 in the same cycle, the new operation is captured: in_ready = out_ready in DONE.
    - The next state follows the new opcode, so single-cycle ops sustain one result per cycle.
    - If out_ready=1 and in_valid=0, go to IDLE.
- Latency, counted from the accept edge:
  - Single-cycle ops: out_valid high after 1 clock.
  - MUL: out_valid high after WIDTH+1 clocks.
- Registering: all outputs except in_ready are registered. in_ready is combinational from state and out_ready.
- Reset:
  - result=0, zero=1, carry=0, overflow=0, negative=0, illegal=0, out_valid=0, state=IDLE, in_ready=1 after reset.
  - rst asserted mid-MUL aborts it with no output produced.
- Boundary conditions:
  - Shift amount 0 returns in1 unchanged.
  - SRA replicates in1[WIDTH-1].
  - in_valid while in EXEC is ignored; the upstream must hold its data.
  - Inputs are not sampled while in_ready=0.

Optional Feature:
ALU_SEQ_MUL_EN:
- Defined: MUL (1000) is supported via the EXEC state.
- Undefined: the EXEC state, accumulator and counter are not built. 1000 is treated as an illegal opcode (result 0, illegal=1, 1-cycle latency).
- The bench runs both builds.

Test Plan:
1. WIDTH=32, ADD 0xFFFFFFFF + 0x00000001 -> result 0, zero=1, carry=1, overflow=0, out_valid 1 cycle after accept.
2. SUB 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow=1, carry=1, negative=0. Then SLT 0xFFFFFFFF, 0x00000001 -> result 1.
3. Macro defined, MUL 7 * 6 -> result 42 with out_valid exactly 33 clocks after accept, in_ready=0 throughout EXEC. MUL 0xFFFFFFFF * 0xFFFFFFFF -> result 0x00000001.
4. Back-to-back ADDs with out_ready held 1 -> one result per cycle. Then drop out_ready for 3 cycles -> result/flags stable, in_ready=0, no operation lost.
5. SRA 0x80000000 by 31 -> 0xFFFFFFFF. SLL 0x1 by in2=0x00000024 (shift 4) -> 0x10.
6. Assert rst at EXEC cycle 10 of a MUL -> next cycle out_valid=0, in_ready=1, result=0. Opcode 1111 -> illegal=1, zero=1. Macro undefined, opcode 1000 -> illegal=1 after 1 cycle.
